// File: rtl/osd_charram_wr_arbiter.sv
// Round-robin arbiter sharing the OSD character RAM write port between burst writers.
// Define OSD_ARB_WR_COUNT_EN to build the per-requester accepted-beat counters on wr_count.
module osd_charram_wr_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       ram_we,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_data,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [N_REQ*16-1:0]        wr_count
);

    localparam int GID_W = $clog2(N_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_data_q, ram_data_d;

    logic               accept;
    logic               winner_found;
    logic [GID_W-1:0]   winner;

    // Scanning offsets from high to low lets the lowest offset from rr_ptr win.
    always_comb begin
        int idx;
        idx          = 0;
        winner       = '0;
        winner_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (req_valid[idx]) begin
                winner       = GID_W'(idx);
                winner_found = 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        req_ready  = '0;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                if (!reset) begin
                    req_ready[grant_id_q] = 1'b1;
                end
                accept = req_valid[grant_id_q] && req_ready[grant_id_q];
                if (accept) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = req_addr[grant_id_q*ADDR_W +: ADDR_W];
                    ram_data_d = req_data[grant_id_q*DATA_W +: DATA_W];
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (req_last[grant_id_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_id_q == GID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

`ifdef OSD_ARB_WR_COUNT_EN
    logic [N_REQ*16-1:0] wr_count_q, wr_count_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        wr_count_d = wr_count_q;
        if (accept) begin
            wr_count_d[grant_id_q*16 +: 16] = wr_count_q[grant_id_q*16 +: 16] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;
`else
    assign wr_count = '0;
`endif

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == LOCK);

endmodule

// File: tb/tb_osd_charram_wr_arbiter.sv
// Bench for osd_charram_wr_arbiter: queued burst sources, a per-cycle reference model
// compared on every falling edge, and literal write-order checks per directed scenario.
module tb_osd_charram_wr_arbiter;

    localparam int N_REQ     = 3;
    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;
    localparam int GID_W     = $clog2(N_REQ);

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       ram_data;
    logic [GID_W-1:0]        grant_id;
    logic                    busy;
    logic [N_REQ*16-1:0]     wr_count;

    osd_charram_wr_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
        int                gap;
    } beat_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    beat_t src_q [N_REQ][$];
    wr_t   wr_log[$];
    int    exp_a[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: arbitration rules in plain integers ----------------
    int               m_owner = -1;   // -1 when no grant is held
    int               m_ptr   = 0;
    int               m_beats = 0;
    logic [GID_W-1:0] m_gid   = '0;
    logic             m_we    = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    int               m_cnt [N_REQ];

    always @(posedge clk) begin : model
        int win;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_gid = '0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
            for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
        end else begin
            m_we = 1'b0;
            if (m_owner < 0) begin
                win = -1;
                for (int k = 0; k < N_REQ; k++)
                    if (win < 0 && req_valid[(m_ptr + k) % N_REQ]) win = (m_ptr + k) % N_REQ;
                if (win >= 0) begin
                    m_owner = win;
                    m_gid   = GID_W'(win);
                    m_beats = 0;
                end
            end else if (req_valid[m_owner]) begin
                m_we   = 1'b1;
                m_addr = req_addr[m_owner*ADDR_W +: ADDR_W];
                m_data = req_data[m_owner*DATA_W +: DATA_W];
                m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
                m_beats++;
                if (req_last[m_owner] || m_beats == MAX_BURST) begin
                    m_ptr   = (m_owner + 1) % N_REQ;
                    m_owner = -1;
                end
            end
        end
    end

    function automatic logic [N_REQ*16-1:0] exp_wr();
        logic [N_REQ*16-1:0] v;
        v = '0;
`ifdef OSD_ARB_WR_COUNT_EN
        for (int i = 0; i < N_REQ; i++) v[i*16 +: 16] = 16'(m_cnt[i]);
`endif
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        logic [N_REQ-1:0] exp_ready;
        if (chk_en) begin
            exp_ready = '0;
            if (!reset && m_owner >= 0) exp_ready[m_owner] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("busy",      64'(busy),      64'(m_owner >= 0));
            check("grant_id",  64'(grant_id),  64'(m_gid));
            check("ram_we",    64'(ram_we),    64'(m_we));
            check("ram_addr",  64'(ram_addr),  64'(m_addr));
            check("ram_data",  64'(ram_data),  64'(m_data));
            check("wr_count",  64'(wr_count),  64'(exp_wr()));
            if (ram_we) wr_log.push_back({ram_addr, ram_data});
        end
    end

    // ---------------- source driver: one queue of beats per requester ----------------
    always begin : driver
        logic [N_REQ-1:0] acc;
        beat_t b;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                if (b.gap > 0) begin
                    b.gap = b.gap - 1;
                    src_q[i][0] = b;
                end else begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = b.last;
                    req_addr[i*ADDR_W +: ADDR_W] = b.addr;
                    req_data[i*DATA_W +: DATA_W] = b.data;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int r, input int addr, input int data, input bit last, input int gap);
        beat_t b;
        b.addr = ADDR_W'(addr);
        b.data = DATA_W'(data);
        b.last = last;
        b.gap  = gap;
        src_q[r].push_back(b);
    endtask

    function automatic bit src_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N_REQ; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!(src_empty() && !busy && !ram_we) && n < max_cycles) begin
            step(1);
            n++;
        end
        check({name, "_drain_in_time"}, 64'(n < max_cycles), 64'(1));
    endtask

    // Hand-computed write order in exp_a against the DUT's logged writes.
    task automatic check_log(input string name);
        check({name, "_write_count"}, 64'(wr_log.size()), 64'(exp_a.size()));
        for (int k = 0; k < exp_a.size() && k < wr_log.size(); k++)
            check($sformatf("%s_addr[%0d]", name, k), 64'(wr_log[k].addr), 64'(exp_a[k]));
    endtask

    task automatic start_test();
        wr_log.delete();
        exp_a.delete();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_addr  = '0;
        req_data  = '0;
        step(2);
        chk_en = 1'b1;
        check("rst_busy",     64'(busy),     64'(0));
        check("rst_ram_we",   64'(ram_we),   64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_ram_addr", 64'(ram_addr), 64'(0));
        check("rst_wr_count", 64'(wr_count), 64'(0));
        step(1);
        reset = 1'b0;
        step(1);

        // 0x10000 beats from requester 0, forced release every 16 beats; counter wraps to 0.
        start_test();
        for (int k = 0; k < 65536; k++) push(0, k % 2048, k % 256, 1'b0, 0);
        drain("wrap", 75000);
        check("wrap_write_count", 64'(wr_log.size()), 64'(65536));
        check("wrap_wr_count",    64'(wr_count),      64'(0));

        // Single 3-beat burst from requester 1.
        start_test();
        push(1, 'h20B, 'h2B, 1'b0, 0);
        push(1, 'h20C, 'h31, 1'b0, 0);
        push(1, 'h20D, 'h35, 1'b1, 0);
        exp_a = '{'h20B, 'h20C, 'h20D};
        drain("single", 50);
        check_log("single");
        if (wr_log.size() == 3) begin
            check("single_data0", 64'(wr_log[0].data), 64'('h2B));
            check("single_data1", 64'(wr_log[1].data), 64'('h31));
            check("single_data2", 64'(wr_log[2].data), 64'('h35));
        end
`ifdef OSD_ARB_WR_COUNT_EN
        check("single_wr_count", 64'(wr_count), 64'(48'h0000_0003_0000));
`else
        check("single_wr_count", 64'(wr_count), 64'(0));
`endif

        // All three requesters, 2-beat bursts, starting from rr_ptr = 0.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        start_test();
        for (int r = 0; r < N_REQ; r++) begin
            push(r, r*'h100,     'h10 + r, 1'b0, 0);
            push(r, r*'h100 + 1, 'h20 + r, 1'b1, 0);
        end
        exp_a = '{'h000, 'h001, 'h100, 'h101, 'h200, 'h201};
        drain("all3", 100);
        check_log("all3");

        // Requester 2 runs 20 beats; forced release after 16 lets pending requester 0 in.
        start_test();
        for (int b = 0; b < 20; b++) push(2, 'h300 + b, 'h80 + b, b == 19, 0);
        push(0, 'h050, 'hA5, 1'b1, 3);
        exp_a = '{'h300, 'h301, 'h302, 'h303, 'h304, 'h305, 'h306, 'h307,
                  'h308, 'h309, 'h30A, 'h30B, 'h30C, 'h30D, 'h30E, 'h30F,
                  'h050, 'h310, 'h311, 'h312, 'h313};
        drain("maxburst", 200);
        check_log("maxburst");

        // Requester 0 pauses 5 cycles mid-burst; requester 1 must wait for the grant.
        start_test();
        push(0, 'h400, 'h40, 1'b0, 0);
        push(0, 'h401, 'h41, 1'b0, 0);
        push(0, 'h402, 'h42, 1'b0, 5);
        push(0, 'h403, 'h43, 1'b1, 0);
        push(1, 'h140, 'h14, 1'b1, 1);
        exp_a = '{'h400, 'h401, 'h402, 'h403, 'h140};
        drain("stall", 100);
        check_log("stall");

        // Reset on an accepting cycle mid-burst; the next arbitration starts from index 0.
        start_test();
        push(1, 'h1F0, 'h1F, 1'b1, 0);
        drain("pre_rst", 50);
        for (int b = 0; b < 6; b++) push(1, 'h1E0 + b, 'hE0 + b, b == 5, 0);
        n = 0;
        while (src_q[1].size() > 4 && n < 50) begin
            step(1);
            n++;
        end
        check("rst_mid_wait", 64'(n < 50), 64'(1));
        reset = 1'b1;
        step(1);
        check("rst_mid_ram_we",   64'(ram_we),   64'(0));
        check("rst_mid_busy",     64'(busy),     64'(0));
        check("rst_mid_wr_count", 64'(wr_count), 64'(0));
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        step(1);
        reset = 1'b0;
        start_test();
        push(1, 'h1A0, 'h1A, 1'b1, 0);
        push(2, 'h2A0, 'h2A, 1'b1, 0);
        exp_a = '{'h1A0, 'h2A0};
        drain("post_rst", 50);
        check_log("post_rst");

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/osd_charram_wr_arbiter.md
Name: osd_charram_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the OSD character RAM between several writer engines: the string writer, the binary-to-ASCII writer and the offset/manual updater. Each requester streams bursts of (addr, data) beats using a valid/ready handshake. The arbiter locks the port to one requester per burst and forwards accepted beats to the RAM port with a fixed one-cycle latency. It replaces ad-hoc OR/priority muxing so that concurrent writers can no longer corrupt each other's strings.

Parameters:
N_REQ, 3, number of requesters (2..8)
ADDR_W, 11, character RAM address width
DATA_W, 8, character code width
MAX_BURST, 16, maximum beats per grant before forced release (1..256)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester beat valid
req_last  in  N_REQ  marks final beat of a burst
req_addr  in  N_REQ*ADDR_W  packed beat addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  packed beat data; requester i at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  per-requester beat accept (combinational)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM write address (registered)
ram_data  out  DATA_W  RAM write data (registered)
grant_id  out  $clog2(N_REQ)  index of current/last granted requester
busy  out  1  high while a grant is locked
wr_count  out  N_REQ*16  per-requester accepted-beat counters (see optional feature)

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, beat_cnt=0, ram_we=0, ram_addr=0, ram_data=0, wr_count=0. req_ready is forced to 0 while reset is high.
- States: IDLE and LOCK.
- IDLE:
  - req_ready is all zero.
  - If any req_valid bit is set, select the first set index found by searching rr_ptr, rr_ptr+1, ... and wrapping modulo N_REQ.
  - Register grant_id to that index, clear beat_cnt, move to LOCK.
  - This gives one arbitration cycle per burst. No beat is accepted in IDLE.
- LOCK:
  - busy=1.
  - req_ready[grant_id]=1; all other ready bits are 0.
  - A beat is accepted on a cycle where req_valid[grant_id] && req_ready[grant_id].
  - On accept: on the next edge ram_we=1 and ram_addr/ram_data take the granted requester's addr/data; beat_cnt increments.
  - Release occurs on an accepted beat with req_last=1, or on an accepted beat when beat_cnt==MAX_BURST-1. On release: state goes to IDLE and rr_ptr becomes (grant_id+1) mod N_REQ. If both release conditions hold on the same beat, this is a single release.
  - If the granted requester deasserts valid mid-burst, the grant is held with no timeout. Other requesters wait.
- RAM port:
  - ram_we is high exactly on the cycle after each accepted beat, otherwise low.
  - ram_addr/ram_data hold their last values when ram_we is low.
  - Throughput is 1 beat per cycle while locked.
  - Latency is fixed at 1 cycle from accept to RAM write.
- Fairness:
  - After a forced MAX_BURST release, a requester that still asserts valid re-arbitrates normally.
  - A pending other requester wins the next grant.
  - If no other requester is pending, the same requester is re-granted after one IDLE cycle.
- Wrap-around: rr_ptr steps from N_REQ-1 to 0. The search order wraps identically.
- grant_id holds its value in IDLE until the next grant.
- Reset mid-burst:
  - A beat presented in the reset cycle is not accepted (ready=0).
  - ram_we is 0 on the following cycle.
  - The requester must restart its burst.

Optional Feature:
Macro OSD_ARB_WR_COUNT_EN.
- Defined: wr_count[i*16 +: 16] increments by 1 on each accepted beat of requester i, wraps from 0xFFFF to 0, and resets to 0.
- Undefined: no counter logic is built and wr_count is tied to 0. Port list is unchanged.

Test Plan:
- Single requester 1, 3-beat burst (addr 0x20B/0x20C/0x20D, data 0x2B/0x31/0x35, last on third beat) -> arbitration cycle, then ready[1] high, ram_we high for 3 consecutive cycles, each 1 cycle after its accept; busy falls after third beat; rr_ptr=2.
- All three requesters assert valid at rr_ptr=0 with 2-beat bursts -> grants in order 0, 1, 2, each separated by one IDLE cycle; 6 RAM writes total with no interleaving.
- Requester 2 holds valid for a 20-beat burst with no last, MAX_BURST=16 -> forced release after beat 16; requester 0 (pending) gets the next grant; requester 2 resumes afterwards.
- Granted requester drops valid for 5 cycles mid-burst while requester 1 requests -> ready[1] stays 0, grant held, no RAM writes during the gap.
- Reset asserted on an accepting cycle mid-burst -> ram_we=0 next cycle, busy=0, rr_ptr=0, wr_count=0; the next burst arbitrates from index 0.
- With OSD_ARB_WR_COUNT_EN defined, 0x10000 beats from requester 0 -> wr_count[15:0] wraps to 0 and other counters stay 0. With the macro undefined -> wr_count is 0 throughout.
